// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- 8N1 UART receiver with a small show-ahead byte FIFO.
// Synchronises the serial line, validates the start bit at mid-bit, samples
// 8 data bits LSB-first, checks the stop bit and queues good bytes.
// Ports:
//   i_Clock     system clock, rising edge
//   i_Reset     synchronous active-high reset
//   i_enable    1 = accept frames, 0 = abort any frame in progress
//   i_RX        asynchronous serial input, idle high
//   o_RX_Data   head-of-FIFO byte (valid while o_RX_Valid)
//   o_RX_Valid  FIFO not empty
//   i_RX_Ready  consumer accepts the head byte
//   o_Count     bytes held, 0..FIFO_DEPTH
//   o_RX_Busy   receiver is inside a frame
//   o_Frame_Err one-cycle pulse, stop bit was low, byte dropped
//   o_Overrun   one-cycle pulse, good byte arrived with FIFO full, byte dropped
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_W       = 2
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_enable,
  input  logic              i_RX,
  output logic [7:0]        o_RX_Data,
  output logic              o_RX_Valid,
  input  logic              i_RX_Ready,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_RX_Busy,
  output logic              o_Frame_Err,
  output logic              o_Overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_C  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0]  FULL_C  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic              rx_meta_r, rx_sync_r;
  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [2:0]        idx_r, idx_nxt_s;
  logic [7:0]        shift_r, shift_nxt_s;
  logic              push_s, ferr_s;

  logic [7:0]        mem_r [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              full_s, pop_s, wr_en_s, ovr_s;
  logic              frame_err_r, overrun_r;

  // Two-flop synchroniser for the asynchronous serial line (idle high).
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= i_RX;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receiver state register with its bit/clock counters and shift register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      shift_r <= shift_nxt_s;
    end
  end

  // Next-state logic; the clock counter restarts on every state entry and every data bit.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r + CNT_W'(1);
    idx_nxt_s   = idx_r;
    shift_nxt_s = shift_r;
    if (!i_enable) begin
      // Disabling abandons any partial frame without side effects.
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_nxt_s = '0;
          if (!rx_sync_r) begin
            state_nxt_s = ST_START;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_START: begin
          if (cnt_r == HALF_C) begin
            cnt_nxt_s = '0;
            idx_nxt_s = 3'd0;
            // A line back high at mid-start is treated as noise.
            if (!rx_sync_r) begin
              state_nxt_s = ST_DATA;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            state_nxt_s = ST_START;
          end
        end
        ST_DATA: begin
          if (cnt_r == FULL_C) begin
            cnt_nxt_s          = '0;
            shift_nxt_s[idx_r] = rx_sync_r;
            if (idx_r == 3'd7) begin
              state_nxt_s = ST_STOP;
            end else begin
              idx_nxt_s = idx_r + 3'd1;
            end
          end else begin
            state_nxt_s = ST_DATA;
          end
        end
        ST_STOP: begin
          if (cnt_r == FULL_C) begin
            cnt_nxt_s   = '0;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_STOP;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  // Stop-bit outcome: push a good byte or raise a framing error.
  always_comb begin
    push_s = 1'b0;
    ferr_s = 1'b0;
    if (i_enable && (state_r == ST_STOP) && (cnt_r == FULL_C)) begin
      push_s = rx_sync_r;
      ferr_s = !rx_sync_r;
    end else begin
      push_s = 1'b0;
      ferr_s = 1'b0;
    end
  end

  // FIFO control; a simultaneous pop frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    full_s  = (count_r == DEPTH_C);
    pop_s   = (count_r != {(ADDR_W + 1){1'b0}}) && i_RX_Ready;
    wr_en_s = push_s && (!full_s || pop_s);
    ovr_s   = push_s && full_s && !pop_s;
  end

  // FIFO storage, pointers and occupancy count.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + ADDR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + (ADDR_W + 1)'(1);
        2'b01:   count_r <= count_r - (ADDR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered one-cycle event flags.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= ferr_s;
      overrun_r   <= ovr_s;
    end
  end

  assign o_RX_Data   = mem_r[rd_ptr_r];
  assign o_RX_Valid  = (count_r != {(ADDR_W + 1){1'b0}});
  assign o_Count     = count_r;
  assign o_RX_Busy   = (state_r != ST_IDLE);
  assign o_Frame_Err = frame_err_r;
  assign o_Overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo with a shortened bit period.
module tb_uart_rx_fifo;
  localparam int CPB = 16;
  // Cycle within a frame after which raising ready makes the first pop coincide with the stop-bit push.
  localparam int READY_AT = 3 + (CPB - 1) / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst, en, rx, ready;
  logic [7:0] data;
  logic       valid, busy, ferr, ovr;
  logic [2:0] cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int ferr_seen, ovr_seen, valid_cycles;
  bit busy_seen;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .ADDR_W(2)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_enable(en), .i_RX(rx),
    .o_RX_Data(data), .o_RX_Valid(valid), .i_RX_Ready(ready), .o_Count(cnt),
    .o_RX_Busy(busy), .o_Frame_Err(ferr), .o_Overrun(ovr)
  );

  always #25 clk = ~clk;

  // Consumer-side monitor: records accepted bytes and flag pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) got_q.push_back(data);
      if (valid) valid_cycles++;
      if (ferr) ferr_seen++;
      if (ovr) ovr_seen++;
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    ferr_seen = 0; ovr_seen = 0; valid_cycles = 0; busy_seen = 1'b0;
    got_q.delete(); exp_q.delete();
  endtask

  // Drive n_cyc cycles of an 8N1 frame; optionally raise ready at cycle ready_at.
  task automatic drive_frame(input logic [7:0] d, input logic stop_b, input int n_cyc, input int ready_at);
    for (int c = 0; c < n_cyc; c++) begin
      int b;
      b = c / CPB;
      if (b == 0) rx = 1'b0;
      else if (b <= 8) rx = d[b-1];
      else rx = stop_b;
      if (c == ready_at) ready = 1'b1;
      tick(1);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop_b);
    drive_frame(d, stop_b, 10 * CPB, -1);
    rx = 1'b1;
    tick(20 + $urandom_range(0, 10));
  endtask

  task automatic drain(input int max_cyc);
    ready = 1'b1;
    for (int i = 0; i < max_cyc && got_q.size() < exp_q.size(); i++) tick(1);
    tick(2);
  endtask

  task automatic compare_rx(input string tag);
    check_eq({tag, "_n"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check_eq({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(valid), 32'd0);
    check_eq({tag, "_count"}, 32'(cnt), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_data"}, 32'(data), 32'h00);
    check_eq({tag, "_ferr"}, 32'(ferr), 32'd0);
    check_eq({tag, "_ovr"}, 32'(ovr), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    int n_bad;
    rst = 1'b1; en = 1'b1; rx = 1'b1; ready = 1'b0;
    clear_stats();
    tick(4);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(5);

    // Single byte, consumer always ready.
    clear_stats();
    ready = 1'b1;
    exp_q.push_back(8'h3F);
    send(8'h3F, 1'b1);
    check_eq("t1_valid_cycles", valid_cycles, 32'd1);
    check_eq("t1_ferr", ferr_seen, 32'd0);
    check_eq("t1_ovr", ovr_seen, 32'd0);
    check_eq("t1_count", 32'(cnt), 32'd0);
    compare_rx("t1");

    // Fill with consumer stalled; fifth byte overruns.
    clear_stats();
    ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send(8'(k), 1'b1);
      if (k <= 4) exp_q.push_back(8'(k));
    end
    check_eq("t2_count_full", 32'(cnt), 32'd4);
    check_eq("t2_ovr", ovr_seen, 32'd1);
    check_eq("t2_ferr", ferr_seen, 32'd0);
    drain(20);
    compare_rx("t2");
    check_eq("t2_count_empty", 32'(cnt), 32'd0);
    check_eq("t2_ovr_after", ovr_seen, 32'd1);

    // Framing error then a good byte.
    clear_stats();
    ready = 1'b1;
    send(8'hA5, 1'b0);
    check_eq("t3_ferr", ferr_seen, 32'd1);
    check_eq("t3_count", 32'(cnt), 32'd0);
    exp_q.push_back(8'h5A);
    send(8'h5A, 1'b1);
    check_eq("t3_ferr_after", ferr_seen, 32'd1);
    check_eq("t3_ovr", ovr_seen, 32'd0);
    compare_rx("t3");

    // Short low glitch is rejected as a false start.
    clear_stats();
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(30);
    check_eq("t4_busy_seen", 32'(busy_seen), 32'd1);
    check_eq("t4_busy", 32'(busy), 32'd0);
    check_eq("t4_ferr", ferr_seen, 32'd0);
    check_eq("t4_ovr", ovr_seen, 32'd0);
    compare_rx("t4");

    // Full FIFO with a pop on the very edge the fifth byte is pushed.
    clear_stats();
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      send(d, 1'b1);
    end
    check_eq("t5_count_full", 32'(cnt), 32'd4);
    d = 8'($urandom);
    exp_q.push_back(d);
    drive_frame(d, 1'b1, 10 * CPB, READY_AT);
    rx = 1'b1;
    drain(40);
    check_eq("t5_ovr", ovr_seen, 32'd0);
    check_eq("t5_count", 32'(cnt), 32'd0);
    compare_rx("t5");

    // Reset in the middle of a frame with bytes queued.
    clear_stats();
    ready = 1'b0;
    send(8'hC1, 1'b1);
    send(8'hC2, 1'b1);
    check_eq("t6_count_two", 32'(cnt), 32'd2);
    drive_frame(8'h77, 1'b1, 4 * CPB, -1);
    rst = 1'b1;
    rx = 1'b1;
    tick(1);
    check_reset_outputs("t6_reset");
    rst = 1'b0;
    clear_stats();
    tick(5);
    ready = 1'b1;
    exp_q.push_back(8'h12);
    send(8'h12, 1'b1);
    compare_rx("t6_after_reset");

    // Disable in the middle of a frame.
    clear_stats();
    drive_frame(8'h77, 1'b1, 4 * CPB, -1);
    en = 1'b0;
    tick(2);
    check_eq("t6_abort_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    tick(20);
    en = 1'b1;
    check_eq("t6_abort_count", 32'(cnt), 32'd0);
    exp_q.push_back(8'hC3);
    send(8'hC3, 1'b1);
    check_eq("t6_abort_ferr", ferr_seen, 32'd0);
    compare_rx("t6_after_abort");

    // Randomised traffic with occasional bad stop bits.
    clear_stats();
    ready = 1'b1;
    n_bad = 0;
    for (int k = 0; k < 30; k++) begin
      logic bad;
      d = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      if (bad) n_bad++;
      else exp_q.push_back(d);
      send(d, !bad);
    end
    check_eq("rand_ferr", ferr_seen, n_bad);
    check_eq("rand_ovr", ovr_seen, 32'd0);
    compare_rx("rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
